// File: rtl/return_stack_ctrl_pkg.sv
// Shared sizing, stack-entry layout and command encoding for the return stack.
package return_stack_ctrl_pkg;
    localparam int DEPTH = 8;
    localparam int AW    = 12;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          c;
        logic          z;
    } stk_entry_t;

    // Listed in decode priority order, highest first.
    typedef enum logic [2:0] {
        CMD_NONE    = 3'd0,
        CMD_INT_ACK = 3'd1,
        CMD_RETI    = 3'd2,
        CMD_PUSH    = 3'd3,
        CMD_POP     = 3'd4
    } cmd_e;
endpackage

// File: rtl/return_stack_ctrl_if.sv
// Command, interrupt and status signals between the control unit and the return stack.
interface return_stack_ctrl_if #(parameter int AW = return_stack_ctrl_pkg::AW);
    logic          push_i, pop_i, int_ack_i, reti_i;
    logic [AW-1:0] pc_i;
    logic          carry_i, zero_i;
    logic          int_req_i, ien_set_i, ien_clr_i;
    logic [AW-1:0] stk_addr_o;
    logic          carry_o, zero_o, flags_valid_o, int_o;
    logic          ien_o, in_isr_o, empty_o, full_o, err_o;

    modport master (
        output push_i, pop_i, int_ack_i, reti_i, pc_i, carry_i, zero_i,
               int_req_i, ien_set_i, ien_clr_i,
        input  stk_addr_o, carry_o, zero_o, flags_valid_o, int_o,
               ien_o, in_isr_o, empty_o, full_o, err_o
    );
    modport slave (
        input  push_i, pop_i, int_ack_i, reti_i, pc_i, carry_i, zero_i,
               int_req_i, ien_set_i, ien_clr_i,
        output stk_addr_o, carry_o, zero_o, flags_valid_o, int_o,
               ien_o, in_isr_o, empty_o, full_o, err_o
    );
endinterface

// File: rtl/return_stack_ctrl_lifo_mem.sv
// LIFO storage with stack pointer; overflow/underflow requests are ignored here.
module lifo_mem
    import return_stack_ctrl_pkg::*;
#(
    parameter int DEPTH = return_stack_ctrl_pkg::DEPTH
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  stk_entry_t wr_data,
    output stk_entry_t top,
    output logic       empty,
    output logic       full
);
    localparam int SPW = $clog2(DEPTH + 1);
    localparam int IW  = $clog2(DEPTH);

    stk_entry_t       mem [DEPTH];
    logic [SPW-1:0]   sp;
    logic [IW-1:0]    wr_idx, top_idx;

    assign empty   = (sp == '0);
    assign full    = (sp == SPW'(DEPTH));
    assign wr_idx  = IW'(sp);
    assign top_idx = IW'(sp - 1'b1);
    assign top     = empty ? '0 : mem[top_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                sp <= '0;
        else if (push && !full)    sp <= sp + 1'b1;
        else if (pop && !empty)    sp <= sp - 1'b1;
    end

    // Contents are intentionally left unreset; sp alone defines validity.
    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_idx] <= wr_data;
    end
endmodule

// File: rtl/return_stack_ctrl.sv
// Return-address / interrupt-context stack: command decode, interrupt state, flag restore.
module return_stack_ctrl
    import return_stack_ctrl_pkg::*;
#(
    parameter int DEPTH = return_stack_ctrl_pkg::DEPTH,
    parameter int AW    = return_stack_ctrl_pkg::AW
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    return_stack_ctrl_if.slave  bus
);
    cmd_e       cmd;
    logic [2:0] n_cmd;
    logic       multi, mem_push, mem_pop, err_next;
    logic       empty, full, int_pending;
    stk_entry_t wr_data, top;

    always_comb begin
        cmd = CMD_NONE;
        if      (bus.int_ack_i) cmd = CMD_INT_ACK;
        else if (bus.reti_i)    cmd = CMD_RETI;
        else if (bus.push_i)    cmd = CMD_PUSH;
        else if (bus.pop_i)     cmd = CMD_POP;
    end

    assign n_cmd    = {2'b0, bus.int_ack_i} + {2'b0, bus.reti_i}
                    + {2'b0, bus.push_i} + {2'b0, bus.pop_i};
    assign multi    = (n_cmd > 3'd1);
    assign mem_push = (cmd == CMD_INT_ACK) || (cmd == CMD_PUSH);
    assign mem_pop  = (cmd == CMD_RETI) || (cmd == CMD_POP);
    assign err_next = multi || (mem_push && full) || (mem_pop && empty)
                    || ((cmd == CMD_RETI) && !bus.in_isr_o);

    // A plain jsb saves cleared flags; only interrupt entry captures the ALU flags.
    always_comb begin
        wr_data.addr = bus.pc_i;
        wr_data.c    = (cmd == CMD_INT_ACK) ? bus.carry_i : 1'b0;
        wr_data.z    = (cmd == CMD_INT_ACK) ? bus.zero_i  : 1'b0;
    end

    lifo_mem #(.DEPTH(DEPTH)) u_mem (
        .clk     (clk_i),
        .rst_n   (rst_n_i),
        .push    (mem_push),
        .pop     (mem_pop),
        .wr_data (wr_data),
        .top     (top),
        .empty   (empty),
        .full    (full)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            int_pending       <= 1'b0;
            bus.ien_o         <= 1'b0;
            bus.in_isr_o      <= 1'b0;
            bus.carry_o       <= 1'b0;
            bus.zero_o        <= 1'b0;
            bus.flags_valid_o <= 1'b0;
            bus.err_o         <= 1'b0;
        end else begin
            int_pending       <= bus.int_req_i || (int_pending && !bus.int_ack_i);
            bus.err_o         <= bus.err_o || err_next;
            bus.flags_valid_o <= (cmd == CMD_RETI) && !empty;
            if ((cmd == CMD_RETI) && !empty) begin
                bus.carry_o <= top.c;
                bus.zero_o  <= top.z;
            end
            if (cmd == CMD_INT_ACK) begin
                bus.ien_o    <= 1'b0;
                bus.in_isr_o <= 1'b1;
            end else if (cmd == CMD_RETI) begin
                bus.ien_o    <= 1'b1;
                bus.in_isr_o <= 1'b0;
            end else if (bus.ien_clr_i) begin
                bus.ien_o    <= 1'b0;
            end else if (bus.ien_set_i) begin
                bus.ien_o    <= 1'b1;
            end
        end
    end

    assign bus.stk_addr_o = top.addr;
    assign bus.empty_o    = empty;
    assign bus.full_o     = full;
    assign bus.int_o      = int_pending && bus.ien_o && !bus.in_isr_o;
endmodule
